// File: rtl/signed_adder_array_if.sv
// rtl/signed_adder_array_if.sv - input/result handshake bundle for signed_adder_array
interface signed_adder_array_if #(
    parameter int NUM_CH    = 4,
    parameter int IN1_WIDTH = 20,
    parameter int IN2_WIDTH = 32,
    parameter int OUT_WIDTH = 32
);
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_CH*IN1_WIDTH-1:0]   in_a;
    logic [NUM_CH*IN2_WIDTH-1:0]   in_b;
    logic                          in_mode;
    logic                          in_last;
    logic                          out_valid;
    logic                          out_ready;
    logic [NUM_CH*OUT_WIDTH-1:0]   out_data;
    logic [NUM_CH-1:0]             out_sat;

    modport slave (
        input  in_valid, in_a, in_b, in_mode, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

    modport master (
        output in_valid, in_a, in_b, in_mode, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/signed_adder_array.sv
// rtl/signed_adder_array.sv - multi-lane pipelined signed adder / run accumulator
// SIGNED_ADDER_SAT_EN selects clamping with overflow flags; otherwise results wrap.
module signed_adder_array #(
    parameter int NUM_CH    = 4,
    parameter int IN1_WIDTH = 20,
    parameter int IN2_WIDTH = 32,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    signed_adder_array_if.slave  bus
);
    localparam int SUM_W = ((IN1_WIDTH > IN2_WIDTH) ? IN1_WIDTH : IN2_WIDTH) + 1;
    // Wide enough to hold both the ADD sum and the ACC step exactly.
    localparam int EXT_W = (SUM_W > OUT_WIDTH + 1) ? SUM_W : OUT_WIDTH + 1;

    typedef logic signed [EXT_W-1:0] ext_t;
    typedef enum logic {ST_IDLE, ST_RUN} state_t;

`ifdef SIGNED_ADDER_SAT_EN
    localparam ext_t MAX_V = ext_t'({{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
    localparam ext_t MIN_V = ext_t'({{(EXT_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}});

    function automatic logic ovf(input ext_t v);
        return (v > MAX_V) || (v < MIN_V);
    endfunction

    function automatic logic [OUT_WIDTH-1:0] reduce(input ext_t v);
        if (v > MAX_V)
            return MAX_V[OUT_WIDTH-1:0];
        else if (v < MIN_V)
            return MIN_V[OUT_WIDTH-1:0];
        else
            return v[OUT_WIDTH-1:0];
    endfunction
`else
    function automatic logic [OUT_WIDTH-1:0] reduce(input ext_t v);
        return v[OUT_WIDTH-1:0];
    endfunction
`endif

    state_t                              state_q, state_d;
    logic [NUM_CH-1:0][OUT_WIDTH-1:0]    acc_q, acc_d;
    logic [NUM_CH-1:0][OUT_WIDTH-1:0]    s1_data_q, s1_data_d;
    logic [NUM_CH-1:0][OUT_WIDTH-1:0]    out_data_q;
    logic                                s1_emit_q, out_valid_q;
    logic                                adv, accept, fresh, emit;
    ext_t                                add_x [NUM_CH];
    ext_t                                acc_x [NUM_CH];

    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv && reset;
    assign accept       = bus.in_valid && bus.in_ready;
    assign fresh        = (state_q == ST_IDLE);
    assign emit         = accept && (!bus.in_mode || bus.in_last);

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    always_comb begin
        state_d = state_q;
        if (accept && bus.in_mode)
            state_d = bus.in_last ? ST_IDLE : ST_RUN;
    end

    always_comb begin
        acc_d     = acc_q;
        s1_data_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            add_x[i] = ext_t'($signed(bus.in_a[i*IN1_WIDTH +: IN1_WIDTH]))
                     + ext_t'($signed(bus.in_b[i*IN2_WIDTH +: IN2_WIDTH]));
            acc_x[i] = (fresh ? ext_t'(0) : ext_t'($signed(acc_q[i])))
                     + ext_t'($signed(bus.in_a[i*IN1_WIDTH +: IN1_WIDTH]));
            s1_data_d[i] = bus.in_mode ? reduce(acc_x[i]) : reduce(add_x[i]);
            if (accept && bus.in_mode)
                acc_d[i] = reduce(acc_x[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            s1_emit_q   <= 1'b0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            if (adv) begin
                s1_emit_q   <= emit;
                s1_data_q   <= s1_data_d;
                out_valid_q <= s1_emit_q;
                out_data_q  <= s1_data_q;
            end
        end
    end

`ifdef SIGNED_ADDER_SAT_EN
    logic [NUM_CH-1:0] sticky_q, sticky_d, s1_sat_q, s1_sat_d, out_sat_q;
    logic [NUM_CH-1:0] run_ovf;

    // Sticky flags restart with each fresh run; ADD beats never touch them.
    always_comb begin
        sticky_d = sticky_q;
        s1_sat_d = '0;
        run_ovf  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            run_ovf[i]  = (!fresh && sticky_q[i]) || ovf(acc_x[i]);
            s1_sat_d[i] = bus.in_mode ? run_ovf[i] : ovf(add_x[i]);
            if (accept && bus.in_mode)
                sticky_d[i] = run_ovf[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sticky_q  <= '0;
            s1_sat_q  <= '0;
            out_sat_q <= '0;
        end else begin
            sticky_q <= sticky_d;
            if (adv) begin
                s1_sat_q  <= s1_sat_d;
                out_sat_q <= s1_sat_q;
            end
        end
    end

    assign bus.out_sat = out_sat_q;
`else
    assign bus.out_sat = '0;
`endif
endmodule
